// File: rtl/breakout_game_core.sv
// Breakout engine: paddle, bouncing ball, brick map, score/lives and game FSM.
// All game state advances on the frame tick; pixel colour is registered (1 clk latency).
//   state | meaning
//   IDLE  | ball seated on paddle, waiting for serve
//   PLAY  | ball in flight
//   MISS  | ball lost, one tick before re-seat or game over
//   OVER  | no lives left, playfield tinted
//   WIN   | brick map cleared
module breakout_game_core #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int BRICK_COLS = 8,
    parameter int BRICK_ROWS = 4,
    parameter int BRICK_W    = 64,
    parameter int BRICK_H    = 16,
    parameter int BRICK_TOP  = 32,
    parameter int PADDLE_W   = 64,
    parameter int PADDLE_Y   = 440,
    parameter int PADDLE_V   = 4,
    parameter int BALL_SIZE  = 8,
    parameter int BALL_V     = 2,
    parameter int LIVES      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  key,
    input  logic        start,
    input  logic        video_on,
    input  logic [11:0] pixel_x,
    input  logic [11:0] pixel_y,
    output logic [4:0]  r,
    output logic [5:0]  g,
    output logic [4:0]  b,
    output logic [15:0] score,
    output logic [2:0]  lives,
    output logic [2:0]  state
);

    localparam int NB       = BRICK_ROWS * BRICK_COLS;
    localparam int BW_SH    = $clog2(BRICK_W);
    localparam int BH_SH    = $clog2(BRICK_H);
    localparam int PADDLE_H = 8;

    localparam logic [11:0] PAD_MAX   = 12'(H_RES - PADDLE_W);
    localparam logic [11:0] PAD_V     = 12'(PADDLE_V);
    localparam logic [11:0] PAD_START = 12'((H_RES - PADDLE_W) / 2);
    localparam logic [11:0] SEAT_OFF  = 12'(PADDLE_W / 2 - BALL_SIZE / 2);
    localparam logic [11:0] SEAT_Y    = 12'(PADDLE_Y - BALL_SIZE);
    localparam logic [11:0] HALF_BALL = 12'(BALL_SIZE / 2);
    localparam logic [11:0] TOP12     = 12'(BRICK_TOP);
    localparam logic [11:0] COLS12    = 12'(BRICK_COLS);
    localparam logic [11:0] ROWS12    = 12'(BRICK_ROWS);
    localparam logic [11:0] BW_M      = 12'(BRICK_W - 1);
    localparam logic [11:0] BH_M      = 12'(BRICK_H - 1);
    localparam logic [12:0] BS13      = 13'(BALL_SIZE);
    localparam logic [12:0] PW13      = 13'(PADDLE_W);
    localparam logic [12:0] PH13      = 13'(PADDLE_H);
    localparam logic signed [13:0] BV    = 14'(BALL_V);
    localparam logic signed [13:0] X_MAX = 14'(H_RES - BALL_SIZE);
    localparam logic [NB-1:0] ONE_NB  = NB'(1);

    generate
        if (BRICK_W < 2 || (BRICK_W & (BRICK_W - 1)) != 0 ||
            BRICK_H < 2 || (BRICK_H & (BRICK_H - 1)) != 0 ||
            BRICK_COLS < 1 || BRICK_COLS > 16 || BRICK_ROWS < 1 || BRICK_ROWS > 8 ||
            LIVES < 1 || LIVES > 7) begin : g_bad_param
            $error("breakout_game_core: illegal parameter set");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PLAY = 3'd1,
        ST_MISS = 3'd2,
        ST_OVER = 3'd3,
        ST_WIN  = 3'd4
    } game_state_t;

    game_state_t st, st_nxt;

    logic [1:0]    key_s1, key_s2;
    logic          start_s1, start_s2, start_d, start_pend;
    logic          start_evt, tick;
    logic [11:0]   paddle_x, ball_x, ball_y, pad_nxt;
    logic          dir_right, dir_down;
    logic [NB-1:0] bricks;

    assign tick      = (pixel_x == 12'd0) && (pixel_y == 12'(V_RES));
    assign start_evt = start_pend | (start_s2 & ~start_d);
    assign state     = st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_s1     <= '0;
            key_s2     <= '0;
            start_s1   <= 1'b0;
            start_s2   <= 1'b0;
            start_d    <= 1'b0;
            start_pend <= 1'b0;
        end else begin
            key_s1     <= key;
            key_s2     <= key_s1;
            start_s1   <= start;
            start_s2   <= start_s1;
            start_d    <= start_s2;
            start_pend <= tick ? 1'b0 : start_evt;
        end
    end

    always_comb begin
        pad_nxt = paddle_x;
        if (key_s2 == 2'b10)
            pad_nxt = (paddle_x >= PAD_MAX - PAD_V) ? PAD_MAX : paddle_x + PAD_V;
        else if (key_s2 == 2'b01)
            pad_nxt = (paddle_x <= PAD_V) ? 12'd0 : paddle_x - PAD_V;
        if (st == ST_OVER || st == ST_WIN)
            pad_nxt = paddle_x;
    end

    logic signed [13:0] nx, ny;
    logic [11:0]   bx_nxt, by_nxt, cx, cy, bcol, brow;
    logic [12:0]   bot;
    logic [15:0]   bidx;
    logic [NB-1:0] hit_mask;
    logic          dr_nxt, dd_nxt, hit;

    assign nx = $signed({2'b00, ball_x}) + (dir_right ? BV : -BV);
    assign ny = $signed({2'b00, ball_y}) + (dir_down  ? BV : -BV);

    always_comb begin
        bx_nxt = nx[11:0];
        by_nxt = ny[11:0];
        dr_nxt = dir_right;
        dd_nxt = dir_down;
        if (nx <= 14'sd0) begin
            bx_nxt = 12'd0;
            dr_nxt = 1'b1;
        end else if (nx >= X_MAX) begin
            bx_nxt = X_MAX[11:0];
            dr_nxt = 1'b0;
        end
        if (ny <= 14'sd0) begin
            by_nxt = 12'd0;
            dd_nxt = 1'b1;
        end
        bot = {1'b0, by_nxt} + BS13;
        if (dd_nxt && bot >= 13'(PADDLE_Y) && bot <= 13'(PADDLE_Y + BALL_V) &&
            ({1'b0, bx_nxt} + BS13) > {1'b0, pad_nxt} &&
            {1'b0, bx_nxt} < ({1'b0, pad_nxt} + PW13))
            dd_nxt = 1'b0;
        // Brick lookup uses the ball centre at its new position.
        cx       = bx_nxt + HALF_BALL;
        cy       = by_nxt + HALF_BALL;
        bcol     = cx >> BW_SH;
        brow     = (cy - TOP12) >> BH_SH;
        bidx     = 16'(brow) * 16'(BRICK_COLS) + 16'(bcol);
        hit_mask = ONE_NB << bidx;
        hit      = (cy >= TOP12) && (bcol < COLS12) && (brow < ROWS12) &&
                   ((bricks & hit_mask) != '0);
        if (hit)
            dd_nxt = ~dd_nxt;
    end

    logic miss_now;
    assign miss_now = ({1'b0, ball_y} + BS13) >= 13'(V_RES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= ST_IDLE;
        else     st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        if (tick) begin
            case (st)
                ST_IDLE: if (start_evt) st_nxt = ST_PLAY;
                ST_PLAY: begin
                    if (bricks == '0)  st_nxt = ST_WIN;
                    else if (miss_now) st_nxt = ST_MISS;
                end
                ST_MISS: st_nxt = (lives == 3'd0) ? ST_OVER : ST_IDLE;
                ST_OVER, ST_WIN: if (start_evt) st_nxt = ST_IDLE;
                default: st_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            paddle_x  <= PAD_START;
            ball_x    <= PAD_START + SEAT_OFF;
            ball_y    <= SEAT_Y;
            dir_right <= 1'b1;
            dir_down  <= 1'b0;
            bricks    <= '1;
            score     <= '0;
            lives     <= 3'(LIVES);
        end else if (tick) begin
            paddle_x <= pad_nxt;
            case (st)
                ST_IDLE: begin
                    ball_x    <= pad_nxt + SEAT_OFF;
                    ball_y    <= SEAT_Y;
                    dir_right <= 1'b1;
                    dir_down  <= 1'b0;
                end
                ST_PLAY: begin
                    if (st_nxt == ST_PLAY) begin
                        ball_x    <= bx_nxt;
                        ball_y    <= by_nxt;
                        dir_right <= dr_nxt;
                        dir_down  <= dd_nxt;
                        if (hit) begin
                            bricks <= bricks & ~hit_mask;
                            if (score != 16'hFFFF) score <= score + 16'd1;
                        end
                    end else if (st_nxt == ST_MISS) begin
                        lives <= lives - 3'd1;
                    end
                end
                ST_MISS: begin
                    if (st_nxt == ST_IDLE) begin
                        ball_x    <= pad_nxt + SEAT_OFF;
                        ball_y    <= SEAT_Y;
                        dir_right <= 1'b1;
                        dir_down  <= 1'b0;
                    end
                end
                ST_OVER, ST_WIN: begin
                    if (st_nxt == ST_IDLE) begin
                        ball_x    <= pad_nxt + SEAT_OFF;
                        ball_y    <= SEAT_Y;
                        dir_right <= 1'b1;
                        dir_down  <= 1'b0;
                        bricks    <= '1;
                        score     <= '0;
                        lives     <= 3'(LIVES);
                    end
                end
                default: ;
            endcase
        end
    end

    logic [11:0]   pcol, prow, prel_y;
    logic [15:0]   pidx;
    logic [NB-1:0] pix_mask;
    logic          ball_px, pad_px, brick_px;
    logic [15:0]   rgb_nxt;

    always_comb begin
        prel_y   = pixel_y - TOP12;
        pcol     = pixel_x >> BW_SH;
        prow     = prel_y >> BH_SH;
        pidx     = 16'(prow) * 16'(BRICK_COLS) + 16'(pcol);
        pix_mask = ONE_NB << pidx;
        // Last pixel column/row of each cell stays black to outline bricks.
        brick_px = (pixel_y >= TOP12) && (pcol < COLS12) && (prow < ROWS12) &&
                   ((bricks & pix_mask) != '0) &&
                   ((pixel_x & BW_M) != BW_M) && ((prel_y & BH_M) != BH_M);
        ball_px  = (pixel_x >= ball_x) && ({1'b0, pixel_x} < {1'b0, ball_x} + BS13) &&
                   (pixel_y >= ball_y) && ({1'b0, pixel_y} < {1'b0, ball_y} + BS13);
        pad_px   = (pixel_x >= paddle_x) && ({1'b0, pixel_x} < {1'b0, paddle_x} + PW13) &&
                   (pixel_y >= 12'(PADDLE_Y)) && ({1'b0, pixel_y} < 13'(PADDLE_Y) + PH13);
        rgb_nxt = 16'h0000;
        if (!video_on)         rgb_nxt = 16'h0000;
        else if (ball_px)      rgb_nxt = {5'd31, 6'd63, 5'd31};
        else if (pad_px)       rgb_nxt = {5'd0,  6'd63, 5'd31};
        else if (brick_px)     rgb_nxt = {5'd31, 6'd0,  5'd0};
        else if (st == ST_OVER) rgb_nxt = {5'd8, 6'd0,  5'd0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= '0;
            g <= '0;
            b <= '0;
        end else begin
            r <= rgb_nxt[15:11];
            g <= rgb_nxt[10:5];
            b <= rgb_nxt[4:0];
        end
    end

endmodule

// File: tb/tb_breakout_game_core.sv
// Directed bench for breakout_game_core: reset, render, paddle, ball physics,
// brick hit, and a full miss/game-over/restart cycle on a 1x1 brick instance.
module tb_breakout_game_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  key;
    logic        start;
    logic        video_on;
    logic [11:0] pixel_x, pixel_y;
    logic [4:0]  r, b, r2, b2;
    logic [5:0]  g, g2;
    logic [15:0] score, score2;
    logic [2:0]  lives, lives2, state, state2;

    int checks   = 0;
    int failures = 0;

    always #20 clk = ~clk;

    breakout_game_core dut (
        .clk(clk), .rst(rst), .key(key), .start(start), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .r(r), .g(g), .b(b),
        .score(score), .lives(lives), .state(state)
    );

    breakout_game_core #(.BRICK_ROWS(1), .BRICK_COLS(1)) dut2 (
        .clk(clk), .rst(rst), .key(key), .start(start), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .r(r2), .g(g2), .b(b2),
        .score(score2), .lives(lives2), .state(state2)
    );

    int rpx [7] = '{600, 320, 300, 10, 63, 10, 320};
    int rpy [7] = '{200, 436, 444, 40, 40, 47, 436};
    bit rvo [7] = '{1, 1, 1, 1, 1, 1, 0};
    int rr  [7] = '{0, 31, 0, 31, 0, 0, 0};
    int rg  [7] = '{0, 63, 63, 0, 0, 0, 0};
    int rb  [7] = '{0, 31, 31, 0, 0, 0, 0};

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pixel_x = 12'd0;
            pixel_y = 12'd480;
            @(negedge clk);
            pixel_x = 12'd1;
            pixel_y = 12'd0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; key = 2'b00; start = 1'b0; video_on = 1'b0;
        pixel_x = 12'd1; pixel_y = 12'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic press_start();
        @(negedge clk);
        start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic set_key(input logic [1:0] k);
        @(negedge clk);
        key = k;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({r, g, b} !== 16'h0000) begin failures++; $display("FAIL reset_rgb got=%h exp=0000", {r, g, b}); end
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (lives !== 3'd3) begin failures++; $display("FAIL reset_lives got=%0d exp=3", lives); end
        checks++; if (score !== 16'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", score); end
        checks++; if (dut.paddle_x !== 12'd288) begin failures++; $display("FAIL reset_paddle got=%0d exp=288", dut.paddle_x); end
        checks++; if (dut.bricks !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_bricks got=%h exp=ffffffff", dut.bricks); end
        checks++; if (dut.ball_x !== 12'd316 || dut.ball_y !== 12'd432) begin
            failures++; $display("FAIL reset_ball got=%0d,%0d exp=316,432", dut.ball_x, dut.ball_y); end
    endtask

    task automatic test_render();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            pixel_x  = 12'(rpx[i]);
            pixel_y  = 12'(rpy[i]);
            video_on = rvo[i];
            if (i == 1) begin
                #1;
                checks++; if (r !== 5'd0) begin failures++; $display("FAIL render_latency r=%0d exp=0 before clock", r); end
            end
            @(negedge clk);
            checks++;
            if (r !== 5'(rr[i]) || g !== 6'(rg[i]) || b !== 5'(rb[i])) begin
                failures++;
                $display("FAIL render_%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, r, g, b, rr[i], rg[i], rb[i]);
            end
        end
        video_on = 1'b0;
        pixel_x = 12'd1; pixel_y = 12'd0;
    endtask

    task automatic test_paddle();
        do_reset();
        set_key(2'b10);
        tick_n(10);
        checks++; if (dut.paddle_x !== 12'd328) begin failures++; $display("FAIL paddle_right10 got=%0d exp=328", dut.paddle_x); end
        tick_n(90);
        checks++; if (dut.paddle_x !== 12'd576) begin failures++; $display("FAIL paddle_clamp got=%0d exp=576", dut.paddle_x); end
        checks++; if (dut.ball_x !== 12'd604) begin failures++; $display("FAIL idle_ball_track got=%0d exp=604", dut.ball_x); end
        set_key(2'b11);
        tick_n(5);
        checks++; if (dut.paddle_x !== 12'd576) begin failures++; $display("FAIL paddle_both got=%0d exp=576", dut.paddle_x); end
        set_key(2'b01);
        tick_n(3);
        checks++; if (dut.paddle_x !== 12'd564 || dut.ball_x !== 12'd592) begin
            failures++; $display("FAIL paddle_left got=%0d/%0d exp=564/592", dut.paddle_x, dut.ball_x); end
        set_key(2'b00);
        tick_n(2);
        checks++; if (dut.paddle_x !== 12'd564 || state !== 3'd0) begin
            failures++; $display("FAIL paddle_hold got=%0d st=%0d exp=564 st=0", dut.paddle_x, state); end
    endtask

    task automatic test_play();
        do_reset();
        press_start();
        tick_n(1);
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL serve_state got=%0d exp=1", state); end
        tick_n(157);
        checks++; if (dut.ball_x !== 12'd630 || dut.ball_y !== 12'd118 || dut.dir_right !== 1'b1) begin
            failures++; $display("FAIL step157 got=%0d,%0d,dr=%b exp=630,118,dr=1", dut.ball_x, dut.ball_y, dut.dir_right); end
        tick_n(1);
        checks++; if (dut.ball_x !== 12'd632 || dut.ball_y !== 12'd116 || dut.dir_right !== 1'b0) begin
            failures++; $display("FAIL right_wall got=%0d,%0d,dr=%b exp=632,116,dr=0", dut.ball_x, dut.ball_y, dut.dir_right); end
        press_start();
        tick_n(1);
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL start_in_play got=%0d exp=1", state); end
        tick_n(56);
        checks++; if (dut.ball_x !== 12'd518 || dut.ball_y !== 12'd2 || dut.dir_down !== 1'b0) begin
            failures++; $display("FAIL step215 got=%0d,%0d,dd=%b exp=518,2,dd=0", dut.ball_x, dut.ball_y, dut.dir_down); end
        tick_n(1);
        checks++; if (dut.ball_x !== 12'd516 || dut.ball_y !== 12'd0 || dut.dir_down !== 1'b1) begin
            failures++; $display("FAIL top_wall got=%0d,%0d,dd=%b exp=516,0,dd=1", dut.ball_x, dut.ball_y, dut.dir_down); end
        tick_n(13);
        checks++; if (dut.ball_y !== 12'd26 || score !== 16'd0 || dut.bricks !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL pre_brick got=y%0d,s%0d,%h exp=y26,s0,ffffffff", dut.ball_y, score, dut.bricks); end
        tick_n(1);
        checks++; if (dut.bricks !== 32'hFFFF_FF7F || score !== 16'd1) begin
            failures++; $display("FAIL brick_hit got=%h,s%0d exp=ffffff7f,s1", dut.bricks, score); end
        checks++; if (dut.ball_x !== 12'd488 || dut.ball_y !== 12'd28 || dut.dir_down !== 1'b0) begin
            failures++; $display("FAIL brick_bounce got=%0d,%0d,dd=%b exp=488,28,dd=0", dut.ball_x, dut.ball_y, dut.dir_down); end
        tick_n(1);
        checks++; if (dut.bricks !== 32'hFFFF_FF7F || score !== 16'd1 || dut.ball_y !== 12'd26) begin
            failures++; $display("FAIL brick_no_rehit got=%h,s%0d,y%0d exp=ffffff7f,s1,y26", dut.bricks, score, dut.ball_y); end
    endtask

    task automatic test_miss_over();
        int n;
        do_reset();
        for (int rnd = 0; rnd < 3; rnd++) begin
            press_start();
            tick_n(1);
            checks++; if (state2 !== 3'd1) begin failures++; $display("FAIL miss_serve%0d got=%0d exp=1", rnd, state2); end
            n = 0;
            while (state2 !== 3'd2 && n < 700) begin
                tick_n(1);
                n++;
            end
            checks++; if (n != 453) begin failures++; $display("FAIL miss_ticks%0d got=%0d exp=453", rnd, n); end
            checks++; if (lives2 !== 3'(2 - rnd)) begin failures++; $display("FAIL miss_lives%0d got=%0d exp=%0d", rnd, lives2, 2 - rnd); end
            tick_n(1);
            checks++; if (state2 !== ((rnd == 2) ? 3'd3 : 3'd0)) begin
                failures++; $display("FAIL after_miss%0d got=%0d exp=%0d", rnd, state2, (rnd == 2) ? 3 : 0); end
        end
        @(negedge clk);
        video_on = 1'b1; pixel_x = 12'd600; pixel_y = 12'd200;
        @(negedge clk);
        checks++; if (r2 !== 5'd8 || g2 !== 6'd0 || b2 !== 5'd0) begin
            failures++; $display("FAIL over_tint got=%0d/%0d/%0d exp=8/0/0", r2, g2, b2); end
        video_on = 1'b0; pixel_x = 12'd1; pixel_y = 12'd0;
        press_start();
        tick_n(1);
        checks++; if (state2 !== 3'd0 || lives2 !== 3'd3 || score2 !== 16'd0 || dut2.bricks !== 1'b1) begin
            failures++; $display("FAIL restart got=st%0d,l%0d,s%0d,br%b exp=st0,l3,s0,br1", state2, lives2, score2, dut2.bricks); end
    endtask

    initial begin
        rst = 1'b1; key = 2'b00; start = 1'b0; video_on = 1'b0;
        pixel_x = 12'd1; pixel_y = 12'd0;
        test_reset();
        test_render();
        test_paddle();
        test_play();
        test_miss_over();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
